tlb_miss_handler: RTL and testbench
===================================

Name: tlb_miss_handler

Overview:
- Hardware page-table walker placed directly behind the TLB.
- On a TLB miss it stalls the pipeline and reads one 32-bit PTE from a single-level page table in physical memory.
- It then refills the TLB through the TLB's write port (virtual page, physical page, one-cycle write enable).
- An invalid PTE raises a page fault to the exception logic.

Parameters:
- OFFSET, `OFFSET (12): page-offset width; VPN = VA[31:OFFSET].
- PHYS_ADDR_SIZE, `PHYS_ADDR_SIZE (20): physical address width.
- PT_BASE, 'h08000: physical base address of the page table, PHYS_ADDR_SIZE bits.
- PTE_VALID_BIT, 31: PTE valid bit position; PPN = PTE[PHYS_ADDR_SIZE-1-OFFSET:0].
- TIMEOUT_CYCLES, 64: memory-ack watchdog limit (only with TLB_MISS_TIMEOUT_EN).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- tlb_miss_i  in  1  miss indication from the TLB.
- virtual_address_i  in  32  address currently presented to the TLB.
- mem_req_o  out  1  PTE read request.
- mem_addr_o  out  PHYS_ADDR_SIZE  PTE physical address.
- mem_ack_i  in  1  read done; mem_data_i is valid in the same cycle.
- mem_data_i  in  32  PTE data.
- w_virtual_page_o  out  32-OFFSET  TLB refill virtual page.
- w_phys_page_o  out  32-OFFSET  TLB refill physical page, PPN zero-extended.
- write_enable_o  out  1  TLB write strobe, exactly one cycle.
- stall_o  out  1  pipeline stall request.
- page_fault_o  out  1  invalid-PTE fault, held until acknowledged.
- fault_address_o  out  32  faulting virtual address.
- fault_ack_i  in  1  exception logic has taken the fault.

Behaviour:
- States: IDLE, REQ, FILL, DONE, FAULT.
- Reset (reset_n=0 at posedge), including mid-walk: state=IDLE; mem_req_o, mem_addr_o, write_enable_o, page_fault_o, fault_address_o, w_* registers all 0. An ack arriving after reset is ignored.
- stall_o is combinational: stall_o = tlb_miss_i | (state!=IDLE). The pipeline therefore stalls in the miss cycle itself.
- IDLE: when tlb_miss_i=1, latch vpn = VA[31:OFFSET] and VA, then go to REQ.
- REQ:
  - mem_req_o=1.
  - mem_addr_o = (PT_BASE + {vpn,2'b00}) mod 2^PHYS_ADDR_SIZE (wrap on overflow).
  - Address is held stable and req stays high until mem_ack_i=1.
  - On ack, capture mem_data_i and drop req in the next cycle. If PTE[PTE_VALID_BIT]=1 go to FILL, else go to FAULT.
- FILL: write_enable_o=1 for exactly one cycle with w_virtual_page_o=vpn and w_phys_page_o=PPN, then go to DONE.
- DONE: one cycle with stall held, so the TLB lookup now hits; then go to IDLE.
  - If tlb_miss_i is still 1 on return to IDLE, a new walk starts (no suppression).
- FAULT:
  - page_fault_o=1 and fault_address_o=latched VA; tlb_miss_i is ignored.
  - On fault_ack_i=1, page_fault_o=0 next cycle and state returns to IDLE.
- Walk latency for a zero-wait-state memory (ack in the first REQ cycle): miss→IDLE is 4 cycles (IDLE, REQ, FILL, DONE).
- Changes on virtual_address_i during a walk are ignored.
- Only one walk is ever outstanding.

Optional Feature:
- TLB_MISS_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES, drop mem_req_o and go to FAULT; page_fault_o is raised as for an invalid PTE.
- Not defined: REQ waits indefinitely for mem_ack_i; no counter logic is present.

Decomposition:
- Shared package / preprocessor_directives: `OFFSET, `PHYS_ADDR_SIZE, PT base, PTE valid-bit position, state encoding constants.
- One natural sub-module: pte_addr_gen, the combinational PT_BASE + vpn*4 computation with wrap.
- FSM, PTE decode and watchdog stay in tlb_miss_handler.

Test Plan:
- Valid PTE: VA=0x00403ABC, miss; ack after 1 cycle with data 0x80000055 → mem_addr_o=0x0900C; write_enable_o pulses once with w_virtual_page_o=0x00403 and w_phys_page_o=0x00055; stall_o drops after DONE.
- Invalid PTE: same VA, data 0x00000055 → no write_enable_o; page_fault_o=1 and fault_address_o=0x00403ABC until fault_ack_i, then IDLE.
- Slow memory: ack delayed 5 cycles → mem_req_o high and mem_addr_o stable for all 5 cycles; stall_o held throughout.
- Address wrap: VA=0xFFFFF000 → mem_addr_o=0x07FFC.
- Reset mid-REQ: reset_n=0 for 1 cycle during REQ, then late ack → outputs 0, IDLE, no TLB write.
- With TLB_MISS_TIMEOUT_EN: no ack for 64 cycles → mem_req_o drops and page_fault_o=1. Without the macro, the handler is still in REQ at cycle 200.

Source files
------------

// File: rtl/tlb_miss_handler_pkg.sv
// Shared constants and state encoding for the TLB miss handler (page-table walker).
// `OFFSET and `PHYS_ADDR_SIZE may be overridden on the command line.
`ifndef OFFSET
`define OFFSET 12
`endif
`ifndef PHYS_ADDR_SIZE
`define PHYS_ADDR_SIZE 20
`endif

package tlb_miss_handler_pkg;
    localparam int OFFSET         = `OFFSET;
    localparam int PHYS_ADDR_SIZE = `PHYS_ADDR_SIZE;
    localparam int VPN_W          = 32 - OFFSET;
    localparam int PPN_W          = PHYS_ADDR_SIZE - OFFSET;
    localparam logic [PHYS_ADDR_SIZE-1:0] PT_BASE = PHYS_ADDR_SIZE'('h08000);
    localparam int PTE_VALID_BIT  = 31;
    localparam int TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        DONE,
        FAULT
    } walk_state_e;
endpackage

// File: rtl/tlb_miss_handler_pte_addr_gen.sv
// PTE address: PT_BASE + vpn*4, wrapping modulo 2^PHYS_ADDR_SIZE.
module tlb_miss_handler_pte_addr_gen
    import tlb_miss_handler_pkg::*;
(
    input  logic [VPN_W-1:0]          vpn_i,
    output logic [PHYS_ADDR_SIZE-1:0] addr_o
);
    logic [VPN_W+1:0] byte_offset;

    assign byte_offset = {vpn_i, 2'b00};
    // Dropping the upper bits before the add gives the wrap for free.
    assign addr_o      = PT_BASE + byte_offset[PHYS_ADDR_SIZE-1:0];
endmodule

// File: rtl/tlb_miss_handler.sv
// Single-level hardware page-table walker behind the TLB: fetch PTE, refill or fault.
// Optional memory-ack watchdog enabled by defining TLB_MISS_TIMEOUT_EN.
module tlb_miss_handler
    import tlb_miss_handler_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      tlb_miss_i,
    input  logic [31:0]               virtual_address_i,
    output logic                      mem_req_o,
    output logic [PHYS_ADDR_SIZE-1:0] mem_addr_o,
    input  logic                      mem_ack_i,
    input  logic [31:0]               mem_data_i,
    output logic [VPN_W-1:0]          w_virtual_page_o,
    output logic [VPN_W-1:0]          w_phys_page_o,
    output logic                      write_enable_o,
    output logic                      stall_o,
    output logic                      page_fault_o,
    output logic [31:0]               fault_address_o,
    input  logic                      fault_ack_i
);
    walk_state_e               state_q, state_d;
    logic [VPN_W-1:0]          vpn_q, vpn_d;
    logic [31:0]               va_q, va_d;
    logic                      mem_req_q, mem_req_d;
    logic [PHYS_ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic                      write_enable_q, write_enable_d;
    logic [VPN_W-1:0]          w_virtual_page_q, w_virtual_page_d;
    logic [VPN_W-1:0]          w_phys_page_q, w_phys_page_d;
    logic                      page_fault_q, page_fault_d;
    logic [31:0]               fault_address_q, fault_address_d;
    logic [PHYS_ADDR_SIZE-1:0] pte_addr;
    logic [VPN_W-1:0]          pte_ppn;
    logic                      timeout;
    logic                      unused_pte_bits;

    tlb_miss_handler_pte_addr_gen u_pte_addr_gen (
        .vpn_i  (virtual_address_i[31:OFFSET]),
        .addr_o (pte_addr)
    );

    assign pte_ppn         = {{(VPN_W-PPN_W){1'b0}}, mem_data_i[PPN_W-1:0]};
    assign unused_pte_bits = ^mem_data_i[PTE_VALID_BIT-1:PPN_W];

`ifdef TLB_MISS_TIMEOUT_EN
    logic [7:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == IDLE) begin
            wd_cnt_d = '0;
        end else if (state_q == REQ && !mem_ack_i) begin
            wd_cnt_d = wd_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) wd_cnt_q <= '0;
        else          wd_cnt_q <= wd_cnt_d;
    end

    assign timeout = (wd_cnt_q == 8'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every *_d is given a default before the case so no latch is inferred.
    always_comb begin
        state_d          = state_q;
        vpn_d            = vpn_q;
        va_d             = va_q;
        mem_req_d        = mem_req_q;
        mem_addr_d       = mem_addr_q;
        write_enable_d   = 1'b0;
        w_virtual_page_d = w_virtual_page_q;
        w_phys_page_d    = w_phys_page_q;
        page_fault_d     = page_fault_q;
        fault_address_d  = fault_address_q;

        unique case (state_q)
            IDLE: begin
                if (tlb_miss_i) begin
                    vpn_d      = virtual_address_i[31:OFFSET];
                    va_d       = virtual_address_i;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pte_addr;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    if (mem_data_i[PTE_VALID_BIT]) begin
                        write_enable_d   = 1'b1;
                        w_virtual_page_d = vpn_q;
                        w_phys_page_d    = pte_ppn;
                        state_d          = FILL;
                    end else begin
                        page_fault_d    = 1'b1;
                        fault_address_d = va_q;
                        state_d         = FAULT;
                    end
                end else if (timeout) begin
                    mem_req_d       = 1'b0;
                    page_fault_d    = 1'b1;
                    fault_address_d = va_q;
                    state_d         = FAULT;
                end
            end
            FILL:    state_d = DONE;
            DONE:    state_d = IDLE;
            FAULT: begin
                if (fault_ack_i) begin
                    page_fault_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            vpn_q            <= '0;
            va_q             <= '0;
            mem_req_q        <= 1'b0;
            mem_addr_q       <= '0;
            write_enable_q   <= 1'b0;
            w_virtual_page_q <= '0;
            w_phys_page_q    <= '0;
            page_fault_q     <= 1'b0;
            fault_address_q  <= '0;
        end else begin
            state_q          <= state_d;
            vpn_q            <= vpn_d;
            va_q             <= va_d;
            mem_req_q        <= mem_req_d;
            mem_addr_q       <= mem_addr_d;
            write_enable_q   <= write_enable_d;
            w_virtual_page_q <= w_virtual_page_d;
            w_phys_page_q    <= w_phys_page_d;
            page_fault_q     <= page_fault_d;
            fault_address_q  <= fault_address_d;
        end
    end

    assign mem_req_o        = mem_req_q;
    assign mem_addr_o       = mem_addr_q;
    assign write_enable_o   = write_enable_q;
    assign w_virtual_page_o = w_virtual_page_q;
    assign w_phys_page_o    = w_phys_page_q;
    assign page_fault_o     = page_fault_q;
    assign fault_address_o  = fault_address_q;
    assign stall_o          = tlb_miss_i | (state_q != IDLE);
endmodule

// File: tb/tb_tlb_miss_handler.sv
// Scoreboard bench for tlb_miss_handler: directed walks push expected events, a monitor checks them.
module tb_tlb_miss_handler;
    import tlb_miss_handler_pkg::*;

    logic                      clock = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      tlb_miss_i = 1'b0;
    logic [31:0]               virtual_address_i = '0;
    logic                      mem_req_o;
    logic [PHYS_ADDR_SIZE-1:0] mem_addr_o;
    logic                      mem_ack_i = 1'b0;
    logic [31:0]               mem_data_i = '0;
    logic [VPN_W-1:0]          w_virtual_page_o;
    logic [VPN_W-1:0]          w_phys_page_o;
    logic                      write_enable_o;
    logic                      stall_o;
    logic                      page_fault_o;
    logic [31:0]               fault_address_o;
    logic                      fault_ack_i = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef enum {EV_REQ, EV_WR, EV_FAULT} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;
    ev_t exp_q[$];

    tlb_miss_handler dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .tlb_miss_i        (tlb_miss_i),
        .virtual_address_i (virtual_address_i),
        .mem_req_o         (mem_req_o),
        .mem_addr_o        (mem_addr_o),
        .mem_ack_i         (mem_ack_i),
        .mem_data_i        (mem_data_i),
        .w_virtual_page_o  (w_virtual_page_o),
        .w_phys_page_o     (w_phys_page_o),
        .write_enable_o    (write_enable_o),
        .stall_o           (stall_o),
        .page_fault_o      (page_fault_o),
        .fault_address_o   (fault_address_o),
        .fault_ack_i       (fault_ack_i)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input ev_kind_t k, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic pop_expect(input ev_kind_t k, input string name, output logic found, output ev_t e);
        found = 1'b0;
        e     = '{EV_REQ, 32'h0, 32'h0};
        if (exp_q.size() == 0 || exp_q[0].kind != k) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s actual=event required=none", name);
        end else begin
            e     = exp_q.pop_front();
            found = 1'b1;
        end
    endtask

    // Monitor: compares DUT events against the scoreboard queue on the falling edge.
    logic req_prev = 1'b0, we_prev = 1'b0, pf_prev = 1'b0;
    always @(negedge clock) begin
        logic found;
        ev_t  e;
        if (reset_n) begin
            if (mem_req_o && !req_prev) begin
                pop_expect(EV_REQ, "mem_req", found, e);
                if (found) check("mem_addr", 32'(mem_addr_o), e.a);
            end
            if (write_enable_o) begin
                check("we_single_cycle", 32'(we_prev), 32'h0);
                pop_expect(EV_WR, "tlb_write", found, e);
                if (found) begin
                    check("w_virtual_page", 32'(w_virtual_page_o), e.a);
                    check("w_phys_page", 32'(w_phys_page_o), e.b);
                end
            end
            if (page_fault_o && !pf_prev) begin
                pop_expect(EV_FAULT, "page_fault", found, e);
                if (found) check("fault_address", fault_address_o, e.a);
            end
        end
        req_prev = mem_req_o;
        we_prev  = write_enable_o;
        pf_prev  = page_fault_o;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic walk(input logic [31:0] va, input logic [31:0] pte, input int delay,
                        input logic [31:0] exp_addr, input logic [31:0] exp_ppn);
        push(EV_REQ, exp_addr, 32'h0);
        if (pte[31]) push(EV_WR, {12'h0, va[31:12]}, exp_ppn);
        else         push(EV_FAULT, va, 32'h0);

        tlb_miss_i        = 1'b1;
        virtual_address_i = va;
        #1;
        check("stall_in_miss_cycle", 32'(stall_o), 32'h1);
        tick();
        tlb_miss_i        = 1'b0;
        virtual_address_i = 32'hDEAD_BEEF;
        for (int i = 0; i < delay; i++) begin
            check("req_held", 32'(mem_req_o), 32'h1);
            check("addr_stable", 32'(mem_addr_o), exp_addr);
            check("stall_in_req", 32'(stall_o), 32'h1);
            tick();
        end
        mem_ack_i  = 1'b1;
        mem_data_i = pte;
        check("req_at_ack", 32'(mem_req_o), 32'h1);
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = 32'h0;
        check("req_dropped", 32'(mem_req_o), 32'h0);
        if (pte[31]) begin
            check("we_in_fill", 32'(write_enable_o), 32'h1);
            check("stall_in_fill", 32'(stall_o), 32'h1);
            tick();
            check("we_off_in_done", 32'(write_enable_o), 32'h0);
            check("stall_in_done", 32'(stall_o), 32'h1);
            tick();
            check("stall_after_done", 32'(stall_o), 32'h0);
        end else begin
            check("no_we_on_fault", 32'(write_enable_o), 32'h0);
            for (int i = 0; i < 3; i++) begin
                tlb_miss_i = 1'b1;
                tick();
                check("fault_held", 32'(page_fault_o), 32'h1);
                check("fault_addr_held", fault_address_o, va);
                check("no_req_in_fault", 32'(mem_req_o), 32'h0);
            end
            tlb_miss_i  = 1'b0;
            fault_ack_i = 1'b1;
            tick();
            fault_ack_i = 1'b0;
            check("fault_cleared", 32'(page_fault_o), 32'h0);
            check("idle_after_ack", 32'(stall_o), 32'h0);
            tick();
            check("no_req_after_ack", 32'(mem_req_o), 32'h0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(mem_req_o), 32'h0);
        check({tag, "_addr"}, 32'(mem_addr_o), 32'h0);
        check({tag, "_we"}, 32'(write_enable_o), 32'h0);
        check({tag, "_wvp"}, 32'(w_virtual_page_o), 32'h0);
        check({tag, "_wpp"}, 32'(w_phys_page_o), 32'h0);
        check({tag, "_pf"}, 32'(page_fault_o), 32'h0);
        check({tag, "_fa"}, fault_address_o, 32'h0);
        check({tag, "_stall"}, 32'(stall_o), 32'h0);
    endtask

    initial begin
        tick();
        tick();
        reset_n = 1'b1;
        check_all_zero("reset");

        // Valid PTE, ack after one wait cycle.
        walk(32'h00403ABC, 32'h80000055, 1, 32'h0900C, 32'h00055);
        // Invalid PTE for the same address.
        walk(32'h00403ABC, 32'h00000055, 0, 32'h0900C, 32'h0);
        // Slow memory: five wait cycles.
        walk(32'h00403ABC, 32'h80000055, 5, 32'h0900C, 32'h00055);
        // Address wrap; only PTE[7:0] forms the PPN.
        walk(32'hFFFFF000, 32'h800ABCDE, 0, 32'h07FFC, 32'h000DE);
        walk(32'h12345678, 32'hC00000A1, 2, 32'h50D14, 32'h000A1);

        // Reset in the middle of REQ, then a late ack that must be ignored.
        push(EV_REQ, 32'h0900C, 32'h0);
        tlb_miss_i        = 1'b1;
        virtual_address_i = 32'h00403ABC;
        tick();
        tlb_miss_i = 1'b0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_all_zero("midreset");
        mem_ack_i  = 1'b1;
        mem_data_i = 32'h80000055;
        tick();
        mem_ack_i  = 1'b0;
        mem_data_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("late_ack_no_we", 32'(write_enable_o), 32'h0);
            check("late_ack_idle", 32'(stall_o), 32'h0);
            tick();
        end

        // Memory never acks.
        push(EV_REQ, 32'h08004, 32'h0);
        tlb_miss_i        = 1'b1;
        virtual_address_i = 32'h00001000;
        tick();
        tlb_miss_i = 1'b0;
`ifdef TLB_MISS_TIMEOUT_EN
        push(EV_FAULT, 32'h00001000, 32'h0);
        begin
            int n = 0;
            while (!page_fault_o && n < 100) begin
                tick();
                n++;
            end
            check("timeout_fault_seen", 32'(page_fault_o), 32'h1);
        end
        check("timeout_req_dropped", 32'(mem_req_o), 32'h0);
        fault_ack_i = 1'b1;
        tick();
        fault_ack_i = 1'b0;
        check("timeout_fault_cleared", 32'(page_fault_o), 32'h0);
`else
        for (int i = 0; i < 200; i++) tick();
        check("no_timeout_req_held", 32'(mem_req_o), 32'h1);
        check("no_timeout_stall_held", 32'(stall_o), 32'h1);
        check("no_timeout_no_fault", 32'(page_fault_o), 32'h0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("recover_idle", 32'(stall_o), 32'h0);
`endif
        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
